// File: rtl/overlap_framer_if.sv
// overlap_framer_if: sample-in / frame-out bus of the overlap framer.
// Slave is the framer side, master is the environment driving samples and taking frames.
interface overlap_framer_if #(
   parameter int DATA_W = 32,
   parameter int CH_W   = 1
);
   localparam int NUM_CH = 2 ** CH_W;
   logic                     s_tvalid;
   logic [NUM_CH*DATA_W-1:0] s_tdata;
   logic [CH_W-1:0]          ch_sel;
   logic                     m_tvalid;
   logic                     m_tready;
   logic [DATA_W-1:0]        m_tdata;
   logic                     m_tlast;
   logic [15:0]              frame_idx;
   logic                     overflow;
   modport master (
      output s_tvalid, s_tdata, ch_sel, m_tready,
      input  m_tvalid, m_tdata, m_tlast, frame_idx, overflow
   );
   modport slave (
      input  s_tvalid, s_tdata, ch_sel, m_tready,
      output m_tvalid, m_tdata, m_tlast, frame_idx, overflow
   );
endinterface

// File: rtl/overlap_framer.sv
// overlap_framer: buffers one lane of a sample stream in a ring and emits
// overlapping FRAME_LEN-sample frames every HOP_LEN samples with backpressure.
module overlap_framer #(
   parameter int DATA_W    = 32,
   parameter int CH_W      = 1,
   parameter int FRAME_LEN = 400,
   parameter int HOP_LEN   = 160,
   parameter int BUF_AW    = 10
) (
   input logic             clk,
   input logic             rst,
   overlap_framer_if.slave bus
);
   localparam int BW = $clog2(FRAME_LEN);
   typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;
   state_t            state, state_n;
   logic [DATA_W-1:0] mem [2**BUF_AW];
   logic [BUF_AW-1:0] wr_ptr, fs_ptr, rd_ptr;
   logic [BUF_AW:0]   occupancy;
   logic [BW-1:0]     beat;
   logic [DATA_W-1:0] lane;
   logic              full, wr_en, last_beat, hs, fetch, retire;
   assign lane      = bus.s_tdata[bus.ch_sel*DATA_W +: DATA_W];
   assign full      = occupancy == (BUF_AW+1)'(2 ** BUF_AW);
   assign wr_en     = bus.s_tvalid && !full;
   assign last_beat = beat == BW'(FRAME_LEN - 1);
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;
   always_comb begin
      state_n = (state == IDLE) ? ((occupancy >= (BUF_AW+1)'(FRAME_LEN)) ? LOAD : IDLE) :
                (state == LOAD) ? EMIT : (retire ? IDLE : EMIT);
   end
   // fetch preloads m_tdata with the next beat so a held-high ready streams one beat per cycle
   always_comb begin
      bus.m_tvalid = state == EMIT;
      bus.m_tlast  = state == EMIT && last_beat;
      hs           = state == EMIT && bus.m_tready;
      retire       = hs && last_beat;
      fetch        = state == LOAD || (hs && !last_beat);
   end
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= lane;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr        <= '0;
         fs_ptr        <= '0;
         rd_ptr        <= '0;
         occupancy     <= '0;
         beat          <= '0;
         bus.m_tdata   <= '0;
         bus.frame_idx <= '0;
         bus.overflow  <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (bus.s_tvalid && full) bus.overflow <= 1'b1;
         occupancy <= occupancy + (BUF_AW+1)'(wr_en) - (retire ? (BUF_AW+1)'(HOP_LEN) : '0);
         if (state == IDLE) rd_ptr <= fs_ptr;
         else if (fetch) rd_ptr <= rd_ptr + 1'b1;
         beat <= (state == IDLE) ? '0 : (hs && !last_beat) ? beat + 1'b1 : beat;
         if (fetch) bus.m_tdata <= mem[rd_ptr];
         if (retire) begin
            fs_ptr        <= fs_ptr + BUF_AW'(HOP_LEN);
            bus.frame_idx <= bus.frame_idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_overlap_framer.sv
// tb_overlap_framer: directed checks of overlapping (8/4) and contiguous (8/8) framing,
// backpressure, overflow, lane select and mid-frame reset.
module tb_overlap_framer;
   logic        clk = 1'b0;
   logic        rst_a, rst_b, rdy_a, rdy_b, s_tvalid, ch_sel;
   logic [63:0] s_tdata;
   int          vec = 0, errs = 0, stab_err = 0;
   bit          rand_mode = 1'b0;
   logic [31:0] da[$], db[$], e[$];
   logic        la[$], lb[$];
   logic [15:0] fa[$], fb[$];
   logic        pa_stall = 1'b0, pa_l = 1'b0;
   logic [31:0] pa_d = '0;
   always #5 clk = ~clk;
   overlap_framer_if #(.DATA_W(32), .CH_W(1)) ifa ();
   overlap_framer_if #(.DATA_W(32), .CH_W(1)) ifb ();
   assign ifa.s_tvalid = s_tvalid;
   assign ifa.s_tdata  = s_tdata;
   assign ifa.ch_sel   = ch_sel;
   assign ifa.m_tready = rdy_a;
   assign ifb.s_tvalid = s_tvalid;
   assign ifb.s_tdata  = s_tdata;
   assign ifb.ch_sel   = ch_sel;
   assign ifb.m_tready = rdy_b;
   overlap_framer #(.DATA_W(32), .CH_W(1), .FRAME_LEN(8), .HOP_LEN(4), .BUF_AW(4))
      dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
   overlap_framer #(.DATA_W(32), .CH_W(1), .FRAME_LEN(8), .HOP_LEN(8), .BUF_AW(4))
      dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));
   // beats are logged where valid&ready is seen, i.e. the handshake on the next edge
   always @(negedge clk) begin
      if (ifa.m_tvalid && rdy_a) begin
         da.push_back(ifa.m_tdata);
         la.push_back(ifa.m_tlast);
         fa.push_back(ifa.frame_idx);
      end
      if (ifb.m_tvalid && rdy_b) begin
         db.push_back(ifb.m_tdata);
         lb.push_back(ifb.m_tlast);
         fb.push_back(ifb.frame_idx);
      end
      if (pa_stall && !rst_a && !(ifa.m_tvalid && ifa.m_tdata === pa_d && ifa.m_tlast === pa_l))
         stab_err <= stab_err + 1;
      pa_stall <= ifa.m_tvalid && !rdy_a && !rst_a;
      pa_d     <= ifa.m_tdata;
      pa_l     <= ifa.m_tlast;
   end
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (rand_mode) rdy_a = 1'($urandom_range(0, 1));
      end
   endtask
   task automatic send(input int v, input int gap);
      s_tvalid = 1'b1;
      s_tdata  = {32'(v + 100), 32'(v)};
      tick(1);
      s_tvalid = 1'b0;
      tick(gap);
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic chk_stream(input string tag, input logic [31:0] d[$], input logic l[$],
                             input logic [15:0] f[$], input logic [31:0] ex[$]);
      chk({tag, " beats"}, d.size(), ex.size());
      for (int i = 0; i < ex.size(); i++) begin
         chk($sformatf("%s data%0d", tag, i), (i < d.size()) ? d[i] : 'x, ex[i]);
         chk($sformatf("%s last%0d", tag, i), (i < l.size()) ? 32'(l[i]) : 'x, 32'(i % 8 == 7));
         chk($sformatf("%s fidx%0d", tag, i), (i < f.size()) ? 32'(f[i]) : 'x, 32'(i / 8));
      end
   endtask
   task automatic reset_a();
      rst_a = 1'b1;
      tick(2);
      rst_a = 1'b0;
      da.delete();
      la.delete();
      fa.delete();
   endtask
   task automatic hop_frames(input int nf);
      e.delete();
      for (int f = 0; f < nf; f++)
         for (int j = 0; j < 8; j++) e.push_back(32'(f * 4 + j + 1));
   endtask
   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
      s_tvalid = 1'b0; s_tdata = '0; ch_sel = 1'b0;
      tick(3);
      @(negedge clk);
      chk("rst m_tvalid", ifa.m_tvalid, 0);
      chk("rst m_tdata", ifa.m_tdata, 0);
      chk("rst m_tlast", ifa.m_tlast, 0);
      chk("rst frame_idx", ifa.frame_idx, 0);
      chk("rst overflow", ifa.overflow, 0);
      rst_a = 1'b0; rst_b = 1'b0;
      tick(1);
      // overlapping frames with ready held high, plus first-beat latency
      for (int k = 1; k <= 7; k++) send(k, 2);
      send(8, 0);
      @(negedge clk); chk("t1 lat N valid", ifa.m_tvalid, 0);
      tick(1);
      @(negedge clk); chk("t1 lat N+1 valid", ifa.m_tvalid, 0);
      tick(1);
      @(negedge clk); chk("t1 lat N+2 valid", ifa.m_tvalid, 1);
      chk("t1 lat N+2 data", ifa.m_tdata, 1);
      tick(1);
      for (int k = 9; k <= 20; k++) send(k, 2);
      tick(40);
      hop_frames(4);
      chk_stream("t1", da, la, fa, e);
      chk("t1 frame_idx end", ifa.frame_idx, 4);
      chk("t1 overflow", ifa.overflow, 0);
      // random backpressure must not alter data order or stability
      reset_a();
      rand_mode = 1'b1;
      for (int k = 1; k <= 20; k++) send(k, 4);
      tick(150);
      rand_mode = 1'b0;
      rdy_a = 1'b1;
      tick(20);
      chk_stream("t2", da, la, fa, e);
      chk("t2 stability", stab_err, 0);
      chk("t2 overflow", ifa.overflow, 0);
      // ring full under stall: sample 17 onwards dropped
      reset_a();
      rdy_a = 1'b0;
      for (int k = 1; k <= 16; k++) send(k, 0);
      @(negedge clk); chk("t3 overflow@16", ifa.overflow, 0);
      send(17, 0);
      @(negedge clk); chk("t3 overflow@17", ifa.overflow, 1);
      chk("t3 stall valid", ifa.m_tvalid, 1);
      chk("t3 stall data", ifa.m_tdata, 1);
      for (int k = 18; k <= 20; k++) send(k, 0);
      rdy_a = 1'b1;
      tick(50);
      hop_frames(3);
      chk_stream("t3", da, la, fa, e);
      chk("t3 overflow sticky", ifa.overflow, 1);
      chk("t3 stability", stab_err, 0);
      // lane 1 selected, then lane 0 while frame 0 is being emitted
      reset_a();
      ch_sel = 1'b1;
      for (int k = 1; k <= 8; k++) send(k, 2);
      ch_sel = 1'b0;
      for (int k = 9; k <= 12; k++) send(k, 2);
      tick(40);
      e.delete();
      for (int k = 101; k <= 108; k++) e.push_back(32'(k));
      for (int k = 105; k <= 108; k++) e.push_back(32'(k));
      for (int k = 9; k <= 12; k++) e.push_back(32'(k));
      chk_stream("t4", da, la, fa, e);
      // reset while beat 3 of frame 0 is presented
      reset_a();
      for (int k = 1; k <= 8; k++) send(k, 0);
      tick(5);
      @(negedge clk); chk("t5 beat3 data", ifa.m_tdata, 4);
      rst_a = 1'b1;
      tick(1);
      rst_a = 1'b0;
      @(negedge clk);
      chk("t5 valid after rst", ifa.m_tvalid, 0);
      chk("t5 last after rst", ifa.m_tlast, 0);
      chk("t5 frame_idx after rst", ifa.frame_idx, 0);
      chk("t5 overflow after rst", ifa.overflow, 0);
      da.delete(); la.delete(); fa.delete();
      tick(1);
      for (int k = 201; k <= 208; k++) send(k, 2);
      tick(30);
      e.delete();
      for (int k = 201; k <= 208; k++) e.push_back(32'(k));
      chk_stream("t5", da, la, fa, e);
      // contiguous frames when HOP_LEN equals FRAME_LEN
      rst_b = 1'b1;
      tick(2);
      rst_b = 1'b0;
      db.delete(); lb.delete(); fb.delete();
      for (int k = 1; k <= 24; k++) send(k, 2);
      tick(40);
      e.delete();
      for (int k = 1; k <= 24; k++) e.push_back(32'(k));
      chk_stream("t6", db, lb, fb, e);
      chk("t6 frame_idx end", ifb.frame_idx, 3);
      chk("t6 overflow", ifb.overflow, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
